// File: rtl/nand_tester.sv
`default_nettype none
// ============================================================================
// Module      : nand_tester
// Description : Self-checking sweep of a 2-input nand cell. Drives all four
//               A/B vectors NUM_PASSES times, compares the cell output with
//               ~(A&B), and reports an error count and a per-vector fail map.
//               Optional: NAND_TESTER_STOP_ON_FAIL_EN ends the run at the
//               first mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module nand_tester #(
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_PASSES    = 2,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dut_out,
    output logic             a_drv,
    output logic             b_drv,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    localparam int c_sw = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int c_pw = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [c_sw-1:0]  c_settle_last = c_sw'(SETTLE_CYCLES - 1);
    localparam logic [c_pw-1:0]  c_pass_last   = c_pw'(NUM_PASSES - 1);
    localparam logic [ERR_W-1:0] c_err_max     = '1;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_drive  = 2'd1;
    localparam logic [1:0] c_st_sample = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [1:0]      r_v;
    logic [1:0]      w_v_inc;
    logic [c_pw-1:0] r_pass_cnt;
    logic [c_sw-1:0] r_settle_cnt;
    logic            w_expected;
    logic            w_mismatch;
    logic            w_last;
    logic            w_stop;

    assign w_expected = ~(r_v[0] & r_v[1]);
    // Case inequality so an X/Z from the cell is reported as a failure.
    assign w_mismatch = (dut_out !== w_expected);
    assign w_last     = (r_v == 2'd3) && (r_pass_cnt == c_pass_last);
    assign w_v_inc    = r_v + 2'd1;

`ifdef NAND_TESTER_STOP_ON_FAIL_EN
    assign w_stop = w_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    assign busy = (r_state == c_st_drive) || (r_state == c_st_sample);
    assign done = (r_state == c_st_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:   if (start) w_state_next = c_st_drive;
            c_st_drive:  if (r_settle_cnt == c_settle_last) w_state_next = c_st_sample;
            c_st_sample: w_state_next = (w_last || w_stop) ? c_st_done : c_st_drive;
            default:     w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v          <= 2'd0;
            r_pass_cnt   <= '0;
            r_settle_cnt <= '0;
            a_drv        <= 1'b0;
            b_drv        <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_vec     <= 4'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_v          <= 2'd0;
                        r_pass_cnt   <= '0;
                        r_settle_cnt <= '0;
                        a_drv        <= 1'b0;
                        b_drv        <= 1'b0;
                        pass         <= 1'b0;
                        err_count    <= '0;
                        fail_vec     <= 4'd0;
                    end
                end
                c_st_drive: begin
                    if (r_settle_cnt != c_settle_last) begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                c_st_sample: begin
                    if (w_mismatch) begin
                        if (err_count != c_err_max) begin
                            err_count <= err_count + 1'b1;
                        end
                        fail_vec[r_v] <= 1'b1;
                    end
                    // Verdict includes the sample taken in this same cycle.
                    if (w_last || w_stop) begin
                        pass <= (err_count == '0) && !w_mismatch;
                    end else begin
                        r_v          <= w_v_inc;
                        r_settle_cnt <= '0;
                        a_drv        <= w_v_inc[0];
                        b_drv        <= w_v_inc[1];
                        if (r_v == 2'd3) begin
                            r_pass_cnt <= r_pass_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nand_tester.sv
`default_nettype none
// ============================================================================
// Module      : tb_nand_tester
// Description : Self-checking bench for nand_tester with a programmable cell
//               truth table and a sweep-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nand_tester;

    localparam int SETTLE = 4;
    localparam int NP     = 2;
    localparam int EW     = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          dut_out;
    logic          a_drv;
    logic          b_drv;
    logic          busy;
    logic          done;
    logic          pass;
    logic [EW-1:0] err_count;
    logic [3:0]    fail_vec;
    logic [3:0]    cell_tt;

    int errors = 0;
    int checks = 0;

    // Cell model: truth table indexed by {B,A}.
    assign dut_out = cell_tt[{b_drv, a_drv}];

    nand_tester #(
        .SETTLE_CYCLES(SETTLE),
        .NUM_PASSES   (NP),
        .ERR_W        (EW)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dut_out  (dut_out),
        .a_drv    (a_drv),
        .b_drv    (b_drv),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .fail_vec (fail_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-run expectation from the nand truth rule and the sweep order.
    function automatic void model(input logic [3:0] tt, output int e_err,
                                  output logic [3:0] e_fail, output int e_lat,
                                  output logic [1:0] e_ab);
        bit stopped;
        e_err   = 0;
        e_fail  = 4'd0;
        e_lat   = 1 + NP * 4 * (SETTLE + 1);
        e_ab    = 2'b11;
        stopped = 0;
        for (int p = 0; p < NP; p++) begin
            for (int v = 0; v < 4; v++) begin
                bit good;
                good = !((v % 2 == 1) && (v / 2 == 1));
                if (!stopped && (tt[v] != good)) begin
                    e_err     = (e_err < (1 << EW) - 1) ? e_err + 1 : e_err;
                    e_fail[v] = 1'b1;
`ifdef NAND_TESTER_STOP_ON_FAIL_EN
                    stopped = 1;
                    e_lat   = 1 + (p * 4 + v + 1) * (SETTLE + 1);
                    e_ab    = {v / 2 == 1, v % 2 == 1};
`endif
                end
            end
        end
    endfunction

    task automatic run_and_check(input string name, input logic [3:0] tt, input int hold_req);
        int         e_err;
        logic [3:0] e_fail;
        int         e_lat;
        logic [1:0] e_ab;
        int         lat;
        int         hold;
        bit         got;
        model(tt, e_err, e_fail, e_lat, e_ab);
        // start may stay high through DONE but must be low once IDLE returns.
        hold    = (hold_req > e_lat + 1) ? e_lat + 1 : hold_req;
        cell_tt = tt;
        @(negedge clk);
        start = 1'b1;
        lat   = 0;
        got   = 0;
        while (!got && lat < e_lat + 20) begin
            @(negedge clk);
            lat++;
            if (lat >= hold) start = 1'b0;
            if (lat == 1) begin
                check({name, "_busy_first"}, busy, 1);
                check({name, "_pass_clr"}, pass, 0);
                check({name, "_err_clr"}, err_count, 0);
                check({name, "_ab_first"}, {b_drv, a_drv}, 0);
            end
            if (done) got = 1;
        end
        check({name, "_done_lat"}, lat, e_lat);
        check({name, "_pass"}, pass, (e_err == 0));
        check({name, "_err"}, err_count, e_err);
        check({name, "_fail_vec"}, fail_vec, e_fail);
        check({name, "_ab_hold"}, {b_drv, a_drv}, e_ab);
        repeat (4) begin
            @(negedge clk);
            lat++;
            if (lat >= hold) start = 1'b0;
            check({name, "_idle_after"}, {busy, done}, 0);
        end
        check({name, "_pass_held"}, pass, (e_err == 0));
    endtask

    initial begin
        bit seen;
        rst     = 1'b1;
        start   = 1'b0;
        cell_tt = 4'b0111;
        #12;
        check("reset_outputs", {a_drv, b_drv, busy, done, pass}, 0);
        check("reset_err", err_count, 0);
        check("reset_fail_vec", fail_vec, 0);
        @(negedge clk);
        rst = 1'b0;

        run_and_check("good", 4'b0111, 1);
        run_and_check("stuck1", 4'b1111, 1);
        run_and_check("stuck0", 4'b0000, 1);
        run_and_check("start_held", 4'b0111, 42);

        // Abort mid-run with an asynchronous reset.
        cell_tt = 4'b0111;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_rst_ab", {b_drv, a_drv}, 2'b10);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("rst_async_outputs", {a_drv, b_drv, busy, done, pass}, 0);
        check("rst_async_err", err_count, 0);
        check("rst_async_fail_vec", fail_vec, 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        check("rst_no_done", seen, 0);
        run_and_check("after_rst", 4'b0111, 1);

        for (int r = 0; r < 6; r++) begin
            run_and_check("rnd", 4'($urandom), int'($urandom_range(1, 42)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
